// File: rtl/axi_lite_pwm.sv
// Multi-channel PWM generator behind a reduced AXI4-Lite slave (word-indexed registers).
// Define AXI_PWM_SHADOW_UPDATE_EN to buffer PERIOD/DUTY writes until each channel wraps.
module axi_lite_pwm #(
    parameter int AXI_ADDR_WIDTH  = 5,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int NUM_CHANNELS    = 4,
    parameter int REG_WIDTH       = 16,
    parameter int PRESCALER_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      axi_awvalid,
    output logic                      axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    input  logic                      axi_wvalid,
    output logic                      axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_wdata,
    output logic                      axi_bvalid,
    input  logic                      axi_bready,
    input  logic                      axi_arvalid,
    output logic                      axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                      axi_rvalid,
    input  logic                      axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic                      pwm_enable,
    output logic [NUM_CHANNELS-1:0]   pwm_out
);

    logic                      r_wrAccept;
    logic                      r_bvalid;
    logic                      r_arready;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [PRESCALER_WIDTH-1:0] r_prescale;
    logic [PRESCALER_WIDTH-1:0] r_pcnt;

    logic                      w_wrEn;
    logic                      w_tick;
    logic [AXI_DATA_WIDTH-1:0] w_readValue;
    logic                      w_unusedWdata;
    logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] w_periodRd;
    logic [NUM_CHANNELS-1:0][REG_WIDTH-1:0] w_dutyRd;

    assign axi_awready = r_wrAccept;
    assign axi_wready  = r_wrAccept;
    assign axi_bvalid  = r_bvalid;
    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rdata   = r_rdata;

    assign w_wrEn        = r_wrAccept && axi_awvalid && axi_wvalid;
    assign w_unusedWdata = ^axi_wdata;

    // AW and W are accepted together only; a pending response blocks the next write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrAccept <= 1'b0;
            r_bvalid   <= 1'b0;
        end else begin
            if (r_wrAccept) begin
                r_wrAccept <= 1'b0;
            end else if (axi_awvalid && axi_wvalid && !r_bvalid) begin
                r_wrAccept <= 1'b1;
            end
            if (w_wrEn) begin
                r_bvalid <= 1'b1;
            end else if (r_bvalid && axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            if (r_arready) begin
                r_arready <= 1'b0;
            end else if (axi_arvalid && !r_rvalid) begin
                r_arready <= 1'b1;
            end
            if (r_arready && axi_arvalid) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_readValue;
            end else if (r_rvalid && axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_readValue = '0;
        if (axi_araddr == '0) begin
            w_readValue = AXI_DATA_WIDTH'(r_prescale);
        end
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (axi_araddr == AXI_ADDR_WIDTH'(2*k+1)) begin
                w_readValue = AXI_DATA_WIDTH'(w_periodRd[k]);
            end
            if (axi_araddr == AXI_ADDR_WIDTH'(2*k+2)) begin
                w_readValue = AXI_DATA_WIDTH'(w_dutyRd[k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale <= '0;
        end else if (w_wrEn && axi_awaddr == '0) begin
            r_prescale <= axi_wdata[PRESCALER_WIDTH-1:0];
        end
    end

    assign w_tick = pwm_enable && (r_pcnt >= r_prescale);

    // The >= compare lets a lowered PRESCALE take effect without a long wraparound.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (!pwm_enable || r_pcnt >= r_prescale) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PRESCALER_WIDTH'(1);
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_channel
        logic [REG_WIDTH-1:0] r_period;
        logic [REG_WIDTH-1:0] r_duty;
        logic [REG_WIDTH-1:0] r_cnt;
        logic                 r_pwm;
        logic                 w_periodWr;
        logic                 w_dutyWr;
        logic                 w_wrap;

        assign w_periodWr = w_wrEn && (axi_awaddr == AXI_ADDR_WIDTH'(2*k+1));
        assign w_dutyWr   = w_wrEn && (axi_awaddr == AXI_ADDR_WIDTH'(2*k+2));
        assign w_wrap     = w_tick && (r_cnt >= r_period);

`ifdef AXI_PWM_SHADOW_UPDATE_EN
        logic [REG_WIDTH-1:0] r_periodShadow;
        logic [REG_WIDTH-1:0] r_dutyShadow;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_periodShadow <= '0;
                r_dutyShadow   <= '0;
            end else begin
                if (w_periodWr) r_periodShadow <= axi_wdata[REG_WIDTH-1:0];
                if (w_dutyWr)   r_dutyShadow   <= axi_wdata[REG_WIDTH-1:0];
            end
        end

        // Active copies only change at a period boundary or while stopped.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_period <= '0;
                r_duty   <= '0;
            end else if (!pwm_enable || w_wrap) begin
                r_period <= r_periodShadow;
                r_duty   <= r_dutyShadow;
            end
        end

        assign w_periodRd[k] = r_periodShadow;
        assign w_dutyRd[k]   = r_dutyShadow;
`else
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_period <= '0;
                r_duty   <= '0;
            end else begin
                if (w_periodWr) r_period <= axi_wdata[REG_WIDTH-1:0];
                if (w_dutyWr)   r_duty   <= axi_wdata[REG_WIDTH-1:0];
            end
        end

        assign w_periodRd[k] = r_period;
        assign w_dutyRd[k]   = r_duty;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
                r_pwm <= 1'b0;
            end else if (!pwm_enable) begin
                r_cnt <= '0;
                r_pwm <= 1'b0;
            end else begin
                r_pwm <= (r_cnt < r_duty);
                if (w_wrap) begin
                    r_cnt <= '0;
                end else if (w_tick) begin
                    r_cnt <= r_cnt + REG_WIDTH'(1);
                end
            end
        end

        assign pwm_out[k] = r_pwm;
    end

endmodule

// File: tb/tb_axi_lite_pwm.sv
// Self-checking bench for axi_lite_pwm: register table, AXI handshake corner cases,
// duty measurements and randomized configurations against an arithmetic PWM model.
module tb_axi_lite_pwm;

    logic        clk = 1'b0;
    logic        rst;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [4:0]  axi_awaddr, axi_araddr;
    logic [31:0] axi_wdata, axi_rdata;
    logic        pwm_enable;
    logic [3:0]  pwm_out;

    axi_lite_pwm dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awaddr  (axi_awaddr),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_wdata   (axi_wdata),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rdata   (axi_rdata),
        .pwm_enable  (pwm_enable),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRead;
    } regVec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state: configuration as the bench has written it.
    int   mP;
    int   mN[4];
    int   mD[4];
    int   modelC;
    logic [3:0] expPwm;
    bit   pwmCheckEn = 1'b0;
    int   highCnt[4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Output after the c-th enabled edge is set by which tick slot of the period c falls in.
    always @(posedge clk or posedge rst) begin
        if (rst || !pwm_enable) begin
            modelC = 0;
            expPwm = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                expPwm[k] = (((modelC / (mP + 1)) % (mN[k] + 1)) < mD[k]);
            end
            modelC++;
        end
    end

    always @(negedge clk) begin
        if (pwmCheckEn) checkOutput("pwm_out_model", {28'd0, pwm_out}, {28'd0, expPwm});
    end

    function automatic void modelWrite(input logic [4:0] a, input logic [31:0] d);
        int k;
        if (a == 0) begin
            mP = int'(d[15:0]);
        end else if (a <= 8) begin
            k = (int'(a) - 1) / 2;
            if (a[0]) mN[k] = int'(d[15:0]);
            else      mD[k] = int'(d[15:0]);
        end
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        int k;
        if (a == 0) return 32'(mP);
        if (a > 8) return 32'd0;
        k = (int'(a) - 1) / 2;
        return a[0] ? 32'(mN[k]) : 32'(mD[k]);
    endfunction

    task automatic waitReady(input string name, input bit isWrite);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(isWrite ? axi_awready : axi_arready) && n < 20);
        checkOutput(name, {31'd0, isWrite ? axi_awready : axi_arready}, 32'd1);
    endtask

    task automatic axiWrite(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        axi_awaddr  = a;
        axi_wdata   = d;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        axi_bready  = 1'b1;
        waitReady("awready", 1'b1);
        checkOutput("wready", {31'd0, axi_wready}, 32'd1);
        @(negedge clk);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        modelWrite(a, d);
        checkOutput("bvalid_set", {31'd0, axi_bvalid}, 32'd1);
        @(negedge clk);
        checkOutput("bvalid_clr", {31'd0, axi_bvalid}, 32'd0);
    endtask

    task automatic axiRead(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        axi_araddr  = a;
        axi_arvalid = 1'b1;
        axi_rready  = 1'b1;
        waitReady("arready", 1'b0);
        @(negedge clk);
        axi_arvalid = 1'b0;
        checkOutput("rvalid_set", {31'd0, axi_rvalid}, 32'd1);
        d = axi_rdata;
        @(negedge clk);
        checkOutput("rvalid_clr", {31'd0, axi_rvalid}, 32'd0);
    endtask

    task automatic applyStimulus(input regVec_t v);
        axiWrite(v.addr, v.wdata);
    endtask

    task automatic measureHigh(input int cycles);
        for (int k = 0; k < 4; k++) highCnt[k] = 0;
        @(negedge clk);
        pwm_enable = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) highCnt[k] += int'(pwm_out[k]);
        end
        pwm_enable = 1'b0;
        @(negedge clk);
    endtask

    function automatic int expHigh(input int k, input int cycles);
        int periodClk = (mN[k] + 1) * (mP + 1);
        int onTicks   = (mD[k] < mN[k] + 1) ? mD[k] : mN[k] + 1;
        return (cycles / periodClk) * onTicks * (mP + 1);
    endfunction

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        regVec_t     vecs[11];
        logic [31:0] rd;
        int          n;

        vecs[0]  = '{5'd0,  32'hFFFF_0009, 32'd9};
        vecs[1]  = '{5'd1,  32'h0001_0013, 32'd19};
        vecs[2]  = '{5'd2,  32'd10,        32'd10};
        vecs[3]  = '{5'd3,  32'd9,         32'd9};
        vecs[4]  = '{5'd4,  32'd5,         32'd5};
        vecs[5]  = '{5'd5,  32'd4,         32'd4};
        vecs[6]  = '{5'd6,  32'd2,         32'd2};
        vecs[7]  = '{5'd7,  32'd99,        32'd99};
        vecs[8]  = '{5'd8,  32'hABCD_0019, 32'd25};
        vecs[9]  = '{5'd9,  32'hDEAD_BEEF, 32'd0};
        vecs[10] = '{5'd31, 32'h0000_1234, 32'd0};

        mP = 0;
        for (int k = 0; k < 4; k++) begin mN[k] = 0; mD[k] = 0; end
        rst = 1'b1;
        axi_awvalid = 0; axi_wvalid = 0; axi_bready = 1; axi_awaddr = 0; axi_wdata = 0;
        axi_arvalid = 0; axi_rready = 1; axi_araddr = 0; pwm_enable = 0;

        repeat (2) @(negedge clk);
        checkOutput("rst_handshake", {26'd0, axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, 1'b0}, 32'd0);
        checkOutput("rst_rdata", axi_rdata, 32'd0);
        checkOutput("rst_pwm", {28'd0, pwm_out}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_handshake", {26'd0, axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, 1'b0}, 32'd0);
        pwmCheckEn = 1'b1;
        axiRead(5'd0, rd);
        checkOutput("reset_read0", rd, 32'd0);

        $display("[TB] register table");
        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);
        for (int i = 0; i < 11; i++) begin
            axiRead(vecs[i].addr, rd);
            checkOutput($sformatf("readback_addr%0d", vecs[i].addr), rd, vecs[i].expRead);
        end

        $display("[TB] channel duty measurement");
        measureHigh(1000);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("high_ch%0d", k), 32'(highCnt[k]), 32'(expHigh(k, 1000)));
        checkOutput("high_ch0_plan", 32'(highCnt[0]), 32'd500);
        checkOutput("high_ch3_plan", 32'(highCnt[3]), 32'd250);

        $display("[TB] write backpressure");
        @(negedge clk);
        axi_awaddr = 5'd2; axi_wdata = 32'd12; axi_awvalid = 1; axi_wvalid = 1; axi_bready = 0;
        waitReady("bp_awready_first", 1'b1);
        @(negedge clk);
        modelWrite(5'd2, 32'd12);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_bvalid_hold", {31'd0, axi_bvalid}, 32'd1);
            checkOutput("bp_no_awready", {31'd0, axi_awready}, 32'd0);
            @(negedge clk);
        end
        axi_bready = 1'b1;
        waitReady("bp_awready_second", 1'b1);
        @(negedge clk);
        axi_awvalid = 0; axi_wvalid = 0;
        checkOutput("bp_bvalid_second", {31'd0, axi_bvalid}, 32'd1);
        @(negedge clk);
        checkOutput("bp_bvalid_clr", {31'd0, axi_bvalid}, 32'd0);

        $display("[TB] read backpressure");
        @(negedge clk);
        axi_araddr = 5'd1; axi_arvalid = 1; axi_rready = 0;
        waitReady("rhold_arready", 1'b0);
        @(negedge clk);
        axi_arvalid = 0;
        axi_araddr  = 5'd2;
        for (int i = 0; i < 6; i++) begin
            checkOutput("rhold_rvalid", {31'd0, axi_rvalid}, 32'd1);
            checkOutput("rhold_rdata", axi_rdata, 32'd19);
            @(negedge clk);
        end
        axi_rready = 1'b1;
        @(negedge clk);
        checkOutput("rhold_release", {31'd0, axi_rvalid}, 32'd0);

        $display("[TB] duty0 sequence");
        axiWrite(5'd2, 32'd15);
        measureHigh(200);
        checkOutput("duty15", 32'(highCnt[0]), 32'd150);
        axiWrite(5'd2, 32'd0);
        measureHigh(200);
        checkOutput("duty0", 32'(highCnt[0]), 32'd0);
        axiWrite(5'd2, 32'd20);
        measureHigh(200);
        checkOutput("duty20", 32'(highCnt[0]), 32'd200);
        axiWrite(5'd2, 32'd19);
        measureHigh(200);
        checkOutput("duty19", 32'(highCnt[0]), 32'd190);

        $display("[TB] enable drop");
        axiWrite(5'd2, 32'd20);
        @(negedge clk);
        pwm_enable = 1'b1;
        repeat (37) @(negedge clk);
        checkOutput("drop_before", {31'd0, pwm_out[0]}, 32'd1);
        pwm_enable = 1'b0;
        @(negedge clk);
        checkOutput("drop_after", {28'd0, pwm_out}, 32'd0);
        axiWrite(5'd2, 32'd15);
        @(negedge clk);
        pwm_enable = 1'b1;
        repeat (123) @(negedge clk);
        pwm_enable = 1'b0;
        @(negedge clk);
        checkOutput("drop_mid", {28'd0, pwm_out}, 32'd0);
        pwm_enable = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n += int'(pwm_out[0]);
        end
        checkOutput("restart_high", 32'(n), 32'd150);
        pwm_enable = 1'b0;

        $display("[TB] randomized configurations");
        for (int it = 0; it < 8; it++) begin
            axiWrite(5'd0, 32'($urandom_range(0, 3)));
            for (int k = 0; k < 4; k++) begin
                axiWrite(5'(2*k+1), $urandom_range(0, 7) | ($urandom << 16));
                axiWrite(5'(2*k+2), 32'($urandom_range(0, 9)));
            end
            for (int a = 0; a < 10; a++) begin
                axiRead(5'(a), rd);
                checkOutput($sformatf("rand_read%0d", a), rd, modelRead(5'(a)));
            end
            @(negedge clk);
            pwm_enable = 1'b1;
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                if ($urandom_range(0, 15) == 0) pwm_enable = ~pwm_enable;
            end
            pwm_enable = 1'b0;
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
